pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Detects load-use hazards against the ID/EX stage, squashes wrong-path instructions on EX-stage redirects, and freezes the pipe while data memory is not ready.
- Runs a debug halt/drain/single-step FSM and keeps stall/flush performance counters.
- Drives the hold/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. A bubble clears rd_wen and MemWrite in the target stage.

---
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use, redirect and
// memory-wait hazards, a debug halt/drain/step FSM, and stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_raddr_ID,
    input  logic [4:0]       rs2_raddr_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [4:0]       rd_waddr_EX,
    input  logic             mem_read_EX,
    input  logic             redirect_EX,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    input  logic             halt_req,
    input  logic             step,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] drain_cnt, drain_cnt_nxt;
    logic       mem_wait;
    logic       lu;

    assign mem_wait = dmem_req_MEM & ~dmem_ready;
    assign lu = mem_read_EX & (rd_waddr_EX != 5'd0) &
                ((rs1_used_ID & (rs1_raddr_ID == rd_waddr_EX)) |
                 (rs2_used_ID & (rs2_raddr_ID == rd_waddr_EX)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // A memory wait freezes the FSM, but a halt request from RUN still starts the drain.
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        if (mem_wait) begin
            if (state == RUN && halt_req) begin
                state_nxt     = DRAIN;
                drain_cnt_nxt = DRAIN_LOAD;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (halt_req) begin
                        state_nxt     = DRAIN;
                        drain_cnt_nxt = DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 4'd0) state_nxt = HALTED;
                    else drain_cnt_nxt = drain_cnt - 4'd1;
                end
                HALTED: begin
                    if (!halt_req) state_nxt = RUN;
                    else if (step) state_nxt = STEP;
                end
                STEP: begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        memwb_flush = 1'b0;
        halted      = (state == HALTED);
        if (mem_wait) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
        end else if (redirect_EX) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            unique case (state)
                RUN, STEP: begin
                    if (lu) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                DRAIN: begin
                    pc_stall   = 1'b1;
                    ifid_flush = 1'b1;
                end
                HALTED: begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall)   stall_cnt <= stall_cnt + CNT_W'(1);
            if (idex_flush) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazard priorities, halt/drain/step FSM,
// performance counters and mid-operation reset.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_raddr_ID, rs2_raddr_ID, rd_waddr_EX;
    logic        rs1_used_ID, rs2_used_ID, mem_read_EX, redirect_EX;
    logic        dmem_req_MEM, dmem_ready, halt_req, step;
    logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic        exmem_stall, memwb_flush, halted;
    logic [31:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    // Control vector order: pc_stall ifid_stall ifid_flush idex_stall idex_flush exmem_stall memwb_flush halted
    localparam logic [7:0] IDLE  = 8'b0000_0000;
    localparam logic [7:0] LU    = 8'b1100_1000;
    localparam logic [7:0] REDIR = 8'b0010_1000;
    localparam logic [7:0] MW    = 8'b1101_0110;
    localparam logic [7:0] DRN   = 8'b1010_0000;
    localparam logic [7:0] HALT  = 8'b1100_1001;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_raddr_ID(rs1_raddr_ID), .rs2_raddr_ID(rs2_raddr_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_waddr_EX(rd_waddr_EX), .mem_read_EX(mem_read_EX),
        .redirect_EX(redirect_EX), .dmem_req_MEM(dmem_req_MEM),
        .dmem_ready(dmem_ready), .halt_req(halt_req), .step(step),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_stall(idex_stall), .idex_flush(idex_flush),
        .exmem_stall(exmem_stall), .memwb_flush(memwb_flush), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, pc_stall, ifid_stall, ifid_flush, idex_stall,
                  idex_flush, exmem_stall, memwb_flush, halted}, {24'd0, exp});
    endtask

    task automatic chk_cnt(input string tag, input int s, input int f);
        chk({tag, "_stall_cnt"}, stall_cnt, 32'(s));
        chk({tag, "_flush_cnt"}, flush_cnt, 32'(f));
    endtask

    initial begin
        rst_n = 1'b0;
        rs1_raddr_ID = '0; rs2_raddr_ID = '0; rd_waddr_EX = '0;
        rs1_used_ID = 1'b0; rs2_used_ID = 1'b0; mem_read_EX = 1'b0;
        redirect_EX = 1'b0; dmem_req_MEM = 1'b0; dmem_ready = 1'b0;
        halt_req = 1'b0; step = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk_ctrl("reset_ctrl", IDLE);
        chk_cnt("reset", 0, 0);
        tick();

        // Load-use on rs1, then the x0 destination guard
        mem_read_EX = 1'b1; rd_waddr_EX = 5'd5; rs1_raddr_ID = 5'd5; rs1_used_ID = 1'b1;
        rs2_raddr_ID = 5'd1; rs2_used_ID = 1'b1;
        #1 chk_ctrl("lu_rs1", LU);
        tick();
        chk_cnt("lu_rs1", 1, 1);
        rd_waddr_EX = 5'd0; rs1_raddr_ID = 5'd0;
        #1 chk_ctrl("lu_x0", IDLE);
        tick();
        chk_cnt("lu_x0", 1, 1);
        rd_waddr_EX = 5'd7; rs1_raddr_ID = 5'd3; rs2_raddr_ID = 5'd7;
        #1 chk_ctrl("lu_rs2", LU);
        tick();
        chk_cnt("lu_rs2", 2, 2);
        rs2_used_ID = 1'b0;
        #1 chk_ctrl("lu_rs2_unused", IDLE);
        rs2_used_ID = 1'b1; mem_read_EX = 1'b0;
        #1 chk_ctrl("no_load", IDLE);

        // Redirect beats load-use
        mem_read_EX = 1'b1; rd_waddr_EX = 5'd5; rs1_raddr_ID = 5'd5; rs2_used_ID = 1'b0;
        redirect_EX = 1'b1;
        #1 chk_ctrl("redirect_lu", REDIR);
        tick();
        chk_cnt("redirect_lu", 2, 3);

        // Memory wait beats redirect; redirect acted on once ready
        mem_read_EX = 1'b0; dmem_req_MEM = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk_ctrl("memwait_redirect", MW);
            tick();
        end
        chk_cnt("memwait", 6, 3);
        dmem_ready = 1'b1;
        #1 chk_ctrl("redirect_after_wait", REDIR);
        tick();
        chk_cnt("redirect_after_wait", 6, 4);
        redirect_EX = 1'b0; dmem_req_MEM = 1'b0; dmem_ready = 1'b0; rs1_used_ID = 1'b0;

        // Halt: three drain cycles, load-use ignored, redirect lets the PC move
        halt_req = 1'b1;
        #1 chk_ctrl("halt_req_run", IDLE);
        tick();
        #1 chk_ctrl("drain1", DRN);
        tick();
        mem_read_EX = 1'b1; rd_waddr_EX = 5'd5; rs1_raddr_ID = 5'd5; rs1_used_ID = 1'b1;
        #1 chk_ctrl("drain2_lu_ignored", DRN);
        tick();
        mem_read_EX = 1'b0; rs1_used_ID = 1'b0; redirect_EX = 1'b1;
        #1 chk_ctrl("drain3_redirect", REDIR);
        tick();
        redirect_EX = 1'b0;
        #1 chk_ctrl("halted", HALT);
        chk_cnt("halted", 8, 5);

        // Single step, held by a memory wait, then drain extended by a wait
        step = 1'b1;
        #1 chk_ctrl("halted_step", HALT);
        tick();
        step = 1'b0; dmem_req_MEM = 1'b1;
        #1 chk_ctrl("step_memwait", MW);
        tick();
        dmem_req_MEM = 1'b0;
        #1 chk_ctrl("step_release", IDLE);
        tick();
        chk_cnt("step", 10, 6);
        #1 chk_ctrl("sdrain1", DRN);
        tick();
        dmem_req_MEM = 1'b1;
        #1 chk_ctrl("sdrain_memwait", MW);
        tick();
        dmem_req_MEM = 1'b0;
        #1 chk_ctrl("sdrain2", DRN);
        tick();
        halt_req = 1'b0;
        #1 chk_ctrl("sdrain3_halt_dropped", DRN);
        tick();
        #1 chk_ctrl("rehalted", HALT);
        chk_cnt("rehalted", 14, 6);
        tick();
        #1 chk_ctrl("resume_run", IDLE);
        chk_cnt("resume_run", 15, 7);

        // Synchronous reset in the middle of a drain
        halt_req = 1'b1;
        tick();
        #1 chk_ctrl("rdrain1", DRN);
        tick();
        chk_cnt("rdrain1", 16, 7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; halt_req = 1'b0;
        #1 chk_ctrl("post_reset", IDLE);
        chk_cnt("post_reset", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
